// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types and constants for the delay timer arbiter.
//   state_t  - FSM encoding (IDLE, LOAD, RUN, DONE)
//   DEF_*    - default requester count and counter width
//   delay_t  - delay value at the default counter width
//   rr_next  - round-robin successor of a requester index
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_NUM_CNT_BITS = 4;

    typedef logic [DEF_NUM_CNT_BITS-1:0] delay_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ : request vector
//   rr_ptr     in  IDX_W   : index with highest priority this round
//   valid      out 1       : some request is set
//   winner_idx out IDX_W   : first set bit at or after rr_ptr, wrapping
//   winner_oh  out NUM_REQ : one-hot form of winner_idx
module rr_arbiter
    import delay_timer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner_idx,
    output logic [NUM_REQ-1:0] winner_oh
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        winner_oh  = '0;
        pos        = '0;
        // Scan from rr_ptr upward; the first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[pos]) begin
                valid          = 1'b1;
                winner_idx     = pos;
                winner_oh[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: time-shares one flex_counter among NUM_REQ requesters.
// The round-robin winner's delay is loaded into the counter, the counter is
// cleared and run to rollover, then a one-cycle done pulse goes to the winner.
//   CLK, nRST          : clock, asynchronous active-low reset
//   req, delay_val     : per-requester level request and delay (sampled at grant)
//   grant, done, busy  : owner one-hot, completion pulse, not-idle flag
//   cnt_*              : connections to the shared flex_counter
// Optional build macro DELAY_TIMER_ARB_ABORT_EN: the owner dropping req in
// LOAD or RUN abandons the delay (no done) and returns to IDLE.
module delay_timer_arbiter
    import delay_timer_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0][NUM_CNT_BITS-1:0] delay_val,
    output logic [NUM_REQ-1:0]                   grant,
    output logic [NUM_REQ-1:0]                   done,
    output logic                                 busy,
    output logic                                 cnt_clear,
    output logic                                 cnt_enable,
    output logic [NUM_CNT_BITS-1:0]              cnt_rollover_val,
    input  logic                                 cnt_rollover_flag,
    input  logic [NUM_CNT_BITS-1:0]              cnt_count_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        owner_idx_q, owner_idx_d;
    logic [NUM_REQ-1:0]      owner_oh_q, owner_oh_d;
    logic [NUM_CNT_BITS-1:0] rollover_q, rollover_d;

    logic                    arb_valid;
    logic [IDX_W-1:0]        arb_idx;
    logic [NUM_REQ-1:0]      arb_oh;
    logic                    abort;
    logic [IDX_W-1:0]        ptr_after_owner;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .valid      (arb_valid),
        .winner_idx (arb_idx),
        .winner_oh  (arb_oh)
    );

`ifdef DELAY_TIMER_ARB_ABORT_EN
    assign abort = ~|(req & owner_oh_q);
`else
    assign abort = 1'b0;
`endif

    // The owner just served drops to lowest priority.
    assign ptr_after_owner = IDX_W'(rr_next(int'(owner_idx_q), NUM_REQ));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_idx_q <= '0;
            owner_oh_q  <= '0;
            rollover_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_idx_q <= owner_idx_d;
            owner_oh_q  <= owner_oh_d;
            rollover_q  <= rollover_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_idx_d = owner_idx_q;
        owner_oh_d  = owner_oh_q;
        rollover_d  = rollover_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_idx_d = arb_idx;
                    owner_oh_d  = arb_oh;
                    rollover_d  = delay_val[arb_idx];
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    rr_ptr_d = ptr_after_owner;
                    state_d  = IDLE;
                end else if (rollover_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    rr_ptr_d = ptr_after_owner;
                    state_d  = IDLE;
                end else if (cnt_rollover_flag) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = ptr_after_owner;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant            = (state_q == LOAD || state_q == RUN) ? owner_oh_q : '0;
        done             = (state_q == DONE) ? owner_oh_q : '0;
        busy             = (state_q != IDLE);
        cnt_clear        = (state_q == LOAD);
        cnt_enable       = (state_q == RUN) && !cnt_rollover_flag;
        cnt_rollover_val = rollover_q;
    end

    // The counter is cleared in LOAD and stops at rollover, so it can never
    // pass the loaded value while running.
    run_count_in_range: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q == RUN) |-> (cnt_count_out <= rollover_q));

endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Time-shares one external `flex_counter` between NUM_REQ requesters, each asking for a programmable cycle delay. Round-robin arbitration picks a winner. The block loads the winner's delay into the counter's `rollover_val`, clears the counter, and enables counting until `rollover_flag`. It then returns a one-cycle `done` pulse to that requester. Sits between requesting control FSMs and the shared counter's `flex_counter_if` signals.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `NUM_CNT_BITS`, 4, counter width; must match the attached `flex_counter`
- `CLK` in 1: single clock, rising edge
- `nRST` in 1: asynchronous, active-low reset
- `req` in NUM_REQ: per-requester level request; held until `done` (see Configuration)
- `delay_val` in NUM_REQ×NUM_CNT_BITS: requested delay per requester, sampled at grant
- `grant` out NUM_REQ: one-hot owner of the counter; all-zero when idle
- `done` out NUM_REQ: one-cycle pulse to the owner when its delay expires
- `busy` out 1: high in any state other than IDLE
- `cnt_clear` out 1: drives the counter's `clear`
- `cnt_enable` out 1: drives the counter's `count_enable`
- `cnt_rollover_val` out NUM_CNT_BITS: drives the counter's `rollover_val`
- `cnt_rollover_flag` in 1: counter's `rollover_flag`
- `cnt_count_out` in NUM_CNT_BITS: counter's `count_out`; used only for an assertion

## Operation
- FSM has four states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any `req` bit is set, `rr_arbiter` picks the first set bit at or after `rr_ptr`, wrapping.
  - Register `grant`, latch the winner's `delay_val` into `cnt_rollover_val`, then go to LOAD.
- **LOAD**
  - Drive `cnt_clear`=1 for exactly one cycle.
  - If the latched delay is 0, go to DONE. Otherwise go to RUN.
- **RUN**
  - `cnt_enable` = !`cnt_rollover_flag`.
  - When `cnt_rollover_flag`=1, go to DONE.
- **DONE**
  - `done[winner]`=1 for one cycle, `grant` goes to 0.
  - `rr_ptr` ← (winner+1) mod NUM_REQ, then go to IDLE.
- `cnt_rollover_val` holds its latched value from IDLE exit until the next grant.
- Requests arriving while busy wait. Arbitration happens only in IDLE.
- A requester that drops `req` after `done` and re-raises it gets lowest priority relative to others pending.
- Assertion: in RUN, `cnt_count_out` ≤ `cnt_rollover_val`.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `grant`=0, `done`=0, `busy`=0, `cnt_clear`=0, `cnt_enable`=0, `cnt_rollover_val`=0.
- All outputs are registered or decoded from state only. No combinational path from `req` to outputs.
- Delay K≥1:
  - `req` sampled high at edge 0.
  - LOAD in cycle 1; RUN in cycles 2..K+2; flag seen in cycle K+2.
  - `done` high in cycle K+3.
- Delay 0: `done` in cycle 2.
- Back-to-back:
  - A requester pending during DONE is granted at the next IDLE.
  - There is one idle cycle between a `done` and the next LOAD.
- Reset asserted mid-operation: all outputs go to reset values immediately. No `done` is issued. The counter is not cleared by this block; the next LOAD clears it.
- `delay_val` changes after grant are ignored.

## Configuration
- `DELAY_TIMER_ARB_ABORT_EN` defined:
  - In LOAD or RUN, if `req[winner]` drops, go directly to IDLE.
  - No `done` pulse; `cnt_enable`=0.
  - `rr_ptr` advances as for a normal completion.
- Macro absent: `req` is ignored once granted, and the delay always runs to `done`.

## Structure
- Package `delay_timer_pkg` holds:
  - `state_t` enum (IDLE, LOAD, RUN, DONE)
  - default `NUM_REQ` and `NUM_CNT_BITS` constants
  - `delay_t` typedef, logic [NUM_CNT_BITS-1:0]
- Sub-module `rr_arbiter` (purely combinational): inputs `req`, `rr_ptr`; outputs `valid` and one-hot/index `winner`.
- The bench instantiates `flex_counter` alongside this block and wires the `cnt_*` ports to a `flex_counter_if`.

## Test plan
- **Reset:** assert `nRST`=0 mid-RUN with delay 9 → all outputs 0 within the same cycle; no `done`; after release, state IDLE and `grant`=0.
- **Single request:** `req`=0001, `delay_val[0]`=5 → `grant`=0001 one cycle later; `cnt_rollover_val`=5; `done[0]` exactly 8 cycles after `req` sampled; counter shows 1..5 with flag at 5.
- **Round-robin:** `req`=1111 held, all delays 2 → grants in order 0,1,2,3,0; each `done` 5 cycles apart plus 1 idle cycle.
- **Delay zero:** `req`=0100, `delay_val[2]`=0 → `done[2]` two cycles after sampling; `cnt_enable` never asserted.
- **Priority wrap:** `rr_ptr`=3 after a grant to requester 2, then `req`=0101 → requester 0 wins before requester 2.
- **Abort** (`DELAY_TIMER_ARB_ABORT_EN` defined): drop `req[1]` in RUN with delay 10 → FSM returns to IDLE next cycle, no `done[1]`, `grant`=0. Without the macro, `done[1]` still fires at cycle 13.
